seq_shift_unit: RTL and testbench

//  Multi-cycle shifter. Consumes the packed shift command word {fill, amount, dir} produced by the
//  ALU control path and shifts the operand one bit position per clock.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_cmd_decode.sv | 42 ++++
 rtl/seq_shift_unit.sv | 151 +++++++++++++++
 tb/tb_seq_shift_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the serial shifter and the shift command decoder.
//   - FSM state encodings for seq_shift_unit
//   - Bit positions of the fields inside the packed shift command word
//     {fill, amount, dir}; the fill and amount-MSB positions depend on the
//     command width, so they are provided as helper functions.
//   - Direction encodings
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam int AMT_LSB = 1;
    localparam int DIR_BIT = 0;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Fill bit sits at the top of the command word.
    function automatic int fill_bit(input int width);
        return width - 1;
    endfunction

    // Amount field occupies everything between the fill and direction bits.
    function automatic int amt_msb(input int width);
        return width - 2;
    endfunction

endpackage

// File: rtl/shift_cmd_decode.sv
// -----------------------------------------------------------------------------
// shift_cmd_decode
// Combinational split of a packed shift command word into its fields, with the
// shift amount saturated to WIDTH (a larger request moves every bit out).
// Ports:
//   cmd     in   WIDTH    packed command {fill, amount, dir}
//   dir     out  1        0 = right, 1 = left
//   fill    out  1        bit shifted in at the vacated end
//   amount  out  CNT_W    min(amount field, WIDTH)
// -----------------------------------------------------------------------------
module shift_cmd_decode
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] cmd,
    output logic             dir,
    output logic             fill,
    output logic [CNT_W-1:0] amount
);

    localparam int FILL_BIT = fill_bit(WIDTH);
    localparam int AMT_MSB  = amt_msb(WIDTH);

    logic [AMT_MSB-AMT_LSB:0] amt_field;
    logic [31:0]              amt_ext;

    assign dir       = cmd[DIR_BIT];
    assign fill      = cmd[FILL_BIT];
    assign amt_field = cmd[AMT_MSB:AMT_LSB];
    assign amt_ext   = 32'(amt_field);

    always_comb begin
        if (amt_ext >= 32'(WIDTH)) begin
            amount = CNT_W'(WIDTH);
        end else begin
            amount = CNT_W'(amt_ext);
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
// Multi-cycle shifter: accepts an operand and a packed command word, then moves
// the operand one bit position per clock. Bits leaving the operand are
// collected in overflow in the order they exit.
// Parameters:
//   WIDTH  operand / result / command width (>= 4)
//   OP     0 = logical, 1 = arithmetic (right shifts replicate the sign bit)
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      command and operand present
//   in_ready   out  1      high only while idle
//   in         in   WIDTH  operand
//   shift      in   WIDTH  command {fill, amount, dir}
//   out_valid  out  1      result present, held until out_ready
//   out_ready  in   1      consumer takes the result
//   out        out  WIDTH  shifted operand
//   overflow   out  WIDTH  bits shifted out, in exit order
// -----------------------------------------------------------------------------
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit OP    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   ovf_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               dir_reg;
    logic               fill_reg;

    logic               cmd_dir;
    logic               cmd_fill;
    logic [CNT_W-1:0]   cmd_amount;

    logic               accept;
    logic               step;
    logic               right_fill;
    logic [WIDTH-1:0]   right_data;
    logic [WIDTH-1:0]   right_ovf;
    logic [WIDTH-1:0]   left_data;
    logic [WIDTH-1:0]   left_ovf;

    shift_cmd_decode #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_decode (
        .cmd    (shift),
        .dir    (cmd_dir),
        .fill   (cmd_fill),
        .amount (cmd_amount)
    );

    assign accept = (state_reg == IDLE) && in_valid;
    assign step   = (state_reg == SHIFT) && (count_reg != '0);

    // Arithmetic right shifts keep re-inserting the current MSB, which never
    // changes, so the sign propagates for the whole operation.
    assign right_fill = OP ? data_reg[WIDTH-1] : fill_reg;

    // One-bit step networks, built per bit position.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
        if (gi == WIDTH - 1) begin : g_top
            assign right_data[gi] = right_fill;
            assign right_ovf[gi]  = data_reg[0];
        end else begin : g_not_top
            assign right_data[gi] = data_reg[gi+1];
            assign right_ovf[gi]  = ovf_reg[gi+1];
        end
        if (gi == 0) begin : g_bottom
            assign left_data[gi] = fill_reg;
            assign left_ovf[gi]  = data_reg[WIDTH-1];
        end else begin : g_not_bottom
            assign left_data[gi] = data_reg[gi-1];
            assign left_ovf[gi]  = ovf_reg[gi-1];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)          state_next = SHIFT;
            SHIFT:   if (count_reg == '0)   state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // ---------------- Datapath and counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            ovf_reg   <= '0;
            count_reg <= '0;
            dir_reg   <= DIR_RIGHT;
            fill_reg  <= 1'b0;
        end else if (accept) begin
            data_reg  <= in;
            ovf_reg   <= '0;
            count_reg <= cmd_amount;
            dir_reg   <= cmd_dir;
            fill_reg  <= cmd_fill;
        end else if (step) begin
            if (dir_reg == DIR_LEFT) begin
                data_reg <= left_data;
                ovf_reg  <= left_ovf;
            end else begin
                data_reg <= right_data;
                ovf_reg  <= right_ovf;
            end
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign out      = data_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_seq_shift_unit.sv
module tb_seq_shift_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for the two WIDTH=4 instances (logical and arithmetic).
    logic       in_valid, out_ready;
    logic [3:0] in_w, shift_w;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [3:0] a_out, a_ovf, b_out, b_ovf;

    // WIDTH=5 instance, where the amount field can exceed the width.
    logic       c_in_valid, c_out_ready;
    logic [4:0] c_in, c_shift;
    logic       c_in_ready, c_out_valid;
    logic [4:0] c_out, c_ovf;

    int checks   = 0;
    int failures = 0;

    seq_shift_unit #(.WIDTH(4), .OP(1'b0)) dut_log (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in(in_w), .shift(shift_w), .out_valid(a_out_valid), .out_ready(out_ready),
        .out(a_out), .overflow(a_ovf));

    seq_shift_unit #(.WIDTH(4), .OP(1'b1)) dut_ari (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in(in_w), .shift(shift_w), .out_valid(b_out_valid), .out_ready(out_ready),
        .out(b_out), .overflow(b_ovf));

    seq_shift_unit #(.WIDTH(5), .OP(1'b0)) dut_w5 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in(c_in), .shift(c_shift), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out(c_out), .overflow(c_ovf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the whole multi-step shift computed in one go with integer
    // arithmetic on the operand.
    function automatic void model(input int w, input bit arith, input int in_v, input int sh,
                                  output int o, output int ov, output int amt);
        int mask, dir, fld, fill, f;
        mask = (1 << w) - 1;
        dir  = sh & 1;
        fld  = (sh >> 1) & ((1 << (w - 2)) - 1);
        fill = (sh >> (w - 1)) & 1;
        amt  = (fld > w) ? w : fld;
        if (dir == 0) begin
            f  = arith ? ((in_v >> (w - 1)) & 1) : fill;
            o  = ((in_v >> amt) | (f != 0 ? (mask & ~(mask >> amt)) : 0)) & mask;
            ov = (in_v << (w - amt)) & mask;
        end else begin
            o  = ((in_v << amt) | (fill != 0 ? ((1 << amt) - 1) : 0)) & mask;
            ov = (in_v >> (w - amt)) & mask;
        end
    endfunction

    // Issue one command to both WIDTH=4 units, check latency and results,
    // optionally hold the result for 'hold' cycles, then release it.
    // kn=1 adds checks against fixed expected values for the logical unit.
    task automatic run4(input int in_v, input int sh, input int hold,
                        input bit kn, input int k_out, input int k_ovf, input int k_lat);
        int lo, lv, la, ao, av, aa, lat;
        logic [3:0] held_a, held_b, held_av;
        model(4, 1'b0, in_v, sh, lo, lv, la);
        model(4, 1'b1, in_v, sh, ao, av, aa);
        check("in_ready_idle", {31'd0, a_in_ready}, 1);
        in_valid  = 1'b1;
        in_w      = 4'(in_v);
        shift_w   = 4'(sh);
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_w     = 4'($urandom);
        shift_w  = 4'($urandom);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, la + 1);
        check("ari_valid", {31'd0, b_out_valid}, 1);
        check("log_out", {28'd0, a_out}, lo);
        check("log_ovf", {28'd0, a_ovf}, lv);
        check("ari_out", {28'd0, b_out}, ao);
        check("ari_ovf", {28'd0, b_ovf}, av);
        if (kn) begin
            check("dir_out", {28'd0, a_out}, k_out);
            check("dir_ovf", {28'd0, a_ovf}, k_ovf);
            check("dir_lat", lat, k_lat);
        end
        held_a = a_out; held_b = b_out; held_av = a_ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_w     = 4'($urandom);
            shift_w  = 4'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, a_out_valid}, 1);
            check("hold_in_ready", {31'd0, a_in_ready}, 0);
            check("hold_out", {28'd0, a_out}, {28'd0, held_a});
            check("hold_ovf", {28'd0, a_ovf}, {28'd0, held_av});
            check("hold_ari_out", {28'd0, b_out}, {28'd0, held_b});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("taken_valid", {31'd0, a_out_valid}, 0);
        check("taken_in_ready", {30'd0, b_in_ready, a_in_ready}, 3);
        $display("cmd4 in=%h shift=%h hold=%0d lat=%0d log=%h/%h ari=%h/%h",
                 in_v[3:0], sh[3:0], hold, lat, a_out, a_ovf, b_out, b_ovf);
    endtask

    task automatic run5(input int in_v, input int sh);
        int eo, ev, ea, lat;
        model(5, 1'b0, in_v, sh, eo, ev, ea);
        c_in_valid = 1'b1;
        c_in       = 5'(in_v);
        c_shift    = 5'(sh);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        c_in       = 5'($urandom);
        lat = 0;
        while (!c_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w5_latency", lat, ea + 1);
        check("w5_out", {27'd0, c_out}, eo);
        check("w5_ovf", {27'd0, c_ovf}, ev);
        @(posedge clk); #1;
        check("w5_in_ready", {31'd0, c_in_ready}, 1);
        $display("cmd5 in=%h shift=%h lat=%0d out=%h ovf=%h", in_v[4:0], sh[4:0], lat, c_out, c_ovf);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; in_w = '0; shift_w = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_in = '0; c_shift = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {28'd0, a_out}, 0);
        check("rst_ovf", {28'd0, a_ovf}, 0);
        check("rst_valid", {30'd0, a_out_valid, c_out_valid}, 0);
        rst = 1'b0;
        check("rst_in_ready", {29'd0, a_in_ready, b_in_ready, c_in_ready}, 7);

        // Directed vectors.
        run4(4'b1011, 4'b0100, 0, 1'b1, 4'b0010, 4'b1100, 3);
        check("ari_dir_out", {28'd0, b_out}, 4'b1110);
        check("ari_dir_ovf", {28'd0, b_ovf}, 4'b1100);
        run4(4'b1010, 4'b1011, 0, 1'b1, 4'b0101, 4'b0001, 2);
        run4(4'b0110, 4'b0000, 0, 1'b1, 4'b0110, 4'b0000, 1);
        run4(4'b1001, 4'b0111, 5, 1'b0, 0, 0, 0);

        // Reset in the middle of a shift: amount 3, one step taken.
        in_valid = 1'b1; in_w = 4'b1101; shift_w = 4'b0110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out", {28'd0, a_out}, 0);
        check("abort_ovf", {28'd0, a_ovf}, 0);
        check("abort_valid", {31'd0, a_out_valid}, 0);
        check("abort_in_ready", {31'd0, a_in_ready}, 1);
        $display("abort mid-shift done");
        run4(4'b1101, 4'b0110, 0, 1'b0, 0, 0, 0);

        // Exhaustive sweep of operand and command at WIDTH=4.
        for (int iv = 0; iv < 16; iv++)
            for (int sv = 0; sv < 16; sv++)
                run4(iv, sv, 0, 1'b0, 0, 0, 0);

        // Random commands with random backpressure.
        for (int n = 0; n < 60; n++)
            run4(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
                 1'b0, 0, 0, 0);

        // WIDTH=5: amount field reaches 7, exercising the saturation to 5.
        run5(5'b10110, 5'b00111);     // left, amount 3
        run5(5'b10110, 5'b01010);     // right, amount 5: overflow = operand
        run5(5'b11001, 5'b11110);     // right, amount 7 clamps, fill 1
        run5(5'b01101, 5'b11111);     // left, amount 7 clamps, fill 1
        for (int n = 0; n < 30; n++)
            run5(int'($urandom_range(31)), int'($urandom_range(31)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
